// File: rtl/mips_irq_controller_if.sv
// Bus bundle between coprocessor 0 / data-memory register port and the interrupt controller.
// The controller uses the slave view; the core side uses the master view.
interface mips_irq_controller_if #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
);
    logic [N_IRQ-1:0] i_irq;
    logic             i_we;
    logic [1:0]       i_addr;
    logic [31:0]      i_wdata;
    logic [31:0]      o_rdata;
    logic             o_external_interrupt;
    logic             i_int_ack;
    logic [ID_W-1:0]  o_irq_id;

    modport slave (
        input  i_irq, i_we, i_addr, i_wdata, i_int_ack,
        output o_rdata, o_external_interrupt, o_irq_id
    );

    modport master (
        output i_irq, i_we, i_addr, i_wdata, i_int_ack,
        input  o_rdata, o_external_interrupt, o_irq_id
    );
endinterface

// File: rtl/mips_irq_controller.sv
// Edge-triggered maskable interrupt controller: synchronises request lines, latches pending
// events and presents the lowest-index unmasked one to coprocessor 0 until software writes EOI.
module mips_irq_controller #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mips_irq_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    state_t           state_q, state_d;
    logic             ext_q, ext_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;

    logic [N_IRQ-1:0] irq_edge, active, w1c, ack_clr;
    logic [ID_W-1:0]  winner;
    logic             eoi_wr;
    logic [31:0]      rdata;
    logic             unused_wdata;

    assign irq_edge = sync2_q & ~prev_q;
    assign active   = pending_q & mask_q;
    assign w1c      = (bus.i_we && bus.i_addr == 2'd0) ? bus.i_wdata[N_IRQ-1:0] : '0;
    assign eoi_wr   = bus.i_we && bus.i_addr == 2'd3;
    assign unused_wdata = ^bus.i_wdata;

    // Scanning downward lets the lowest active index overwrite any higher one.
    always_comb begin
        winner = '0;
        for (int n = N_IRQ - 1; n >= 0; n--) begin
            if (active[n]) winner = ID_W'(n);
        end
    end

    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        irq_id_d = irq_id_q;
        ack_clr  = '0;
        case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d  = REQ;
                    ext_d    = 1'b1;
                    irq_id_d = winner;
                end
            end
            REQ: begin
                if (bus.i_int_ack) begin
                    state_d           = SERVICE;
                    ext_d             = 1'b0;
                    ack_clr[irq_id_q] = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge overrides any clear landing in the same cycle.
        pending_d = (pending_q & ~w1c & ~ack_clr) | irq_edge;
        mask_d    = (bus.i_we && bus.i_addr == 2'd1) ? bus.i_wdata[N_IRQ-1:0] : mask_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            state_q   <= IDLE;
            ext_q     <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            sync1_q   <= bus.i_irq;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
            ext_q     <= ext_d;
            irq_id_q  <= irq_id_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.i_addr)
            2'd0: rdata[N_IRQ-1:0] = pending_q;
            2'd1: rdata[N_IRQ-1:0] = mask_q;
            2'd2: begin
                rdata[31]         = (state_q != IDLE);
                rdata[ID_W-1:0]   = irq_id_q;
            end
            default: rdata = '0;
        endcase
    end

    assign bus.o_rdata              = rdata;
    assign bus.o_external_interrupt = ext_q;
    assign bus.o_irq_id             = irq_id_q;
endmodule

// File: tb/tb_mips_irq_controller.sv
// Randomised and directed bench for mips_irq_controller against an event-level reference model.
module tb_mips_irq_controller;
    localparam int N_IRQ = 8;
    localparam int ID_W  = 3;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mips_irq_controller_if #(.N_IRQ(N_IRQ), .ID_W(ID_W)) bus ();

    mips_irq_controller #(.N_IRQ(N_IRQ), .ID_W(ID_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: requests as sets of line indices, mode 0=idle, 1=presenting, 2=in service.
    logic [7:0] m_pend, m_mask;
    int         m_mode;
    logic [2:0] m_id;
    logic       m_ext;
    logic [7:0] hist [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] first_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] addr);
        case (addr)
            2'd0: return {24'b0, m_pend};
            2'd1: return {24'b0, m_mask};
            2'd2: return {(m_mode != 0), 28'b0, m_id};
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_mode = 0; m_id = '0; m_ext = 1'b0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
    endtask

    // A line level seen at the clock edge becomes a pending event two edges later.
    task automatic model_step(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                              input logic ack, input logic [7:0] irq);
        logic [7:0] ev, clr, ready;
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq;
        ev    = hist[2] & ~hist[3];
        clr   = (we && addr == 2'd0) ? wd[7:0] : 8'h00;
        ready = m_pend & m_mask;
        if (m_mode == 0) begin
            if (ready != 0) begin
                m_mode = 1; m_ext = 1'b1; m_id = first_set(ready);
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                clr[m_id] = 1'b1; m_mode = 2; m_ext = 1'b0;
            end
        end else begin
            if (we && addr == 2'd3) m_mode = 0;
        end
        m_pend = (m_pend & ~clr) | ev;
        if (we && addr == 2'd1) m_mask = wd[7:0];
    endtask

    task automatic step(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                        input logic ack, input logic [7:0] irq);
        @(negedge clk);
        bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wd; bus.i_int_ack = ack; bus.i_irq = irq;
        @(posedge clk);
        #1;
        model_step(we, addr, wd, ack, irq);
        chk("ext", {31'b0, bus.o_external_interrupt}, {31'b0, m_ext});
        chk("id", {29'b0, bus.o_irq_id}, {29'b0, m_id});
        chk("rdata", bus.o_rdata, model_rd(addr));
    endtask

    task automatic apply_reset(input logic [7:0] irq_hold);
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.i_we = 1'b0; bus.i_int_ack = 1'b0; bus.i_irq = irq_hold; bus.i_addr = 2'd0;
        model_reset();
        #1;
        chk("rst_ext", {31'b0, bus.o_external_interrupt}, 32'h0);
        chk("rst_id", {29'b0, bus.o_irq_id}, 32'h0);
        chk("rst_pend", bus.o_rdata, 32'h0);
        bus.i_addr = 2'd1;
        #1 chk("rst_mask", bus.o_rdata, 32'h0);
        bus.i_addr = 2'd2;
        #1 chk("rst_status", bus.o_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input logic [1:0] addr, input logic [7:0] irq);
        step(1'b0, addr, 32'h0, 1'b0, irq);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq;
        logic [7:0] r_irq;
        logic       we, ack;
        logic [1:0] addr;
        logic [31:0] wd;

        n_vec = 0; n_err = 0;
        rst = 1'b1;
        bus.i_we = 1'b0; bus.i_addr = 2'd0; bus.i_wdata = '0; bus.i_int_ack = 1'b0; bus.i_irq = '0;
        apply_reset(8'h00);

        // 1: single pulse on line 0, request after the fourth edge
        step(1'b1, 2'd1, 32'h01, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            idle(2'd0, (i == 0) ? 8'h01 : 8'h00);
            seq[i] = bus.o_external_interrupt;
        end
        chk("t1_latency", {28'b0, seq}, 32'h8);
        chk("t1_id", {29'b0, bus.o_irq_id}, 32'h0);
        chk("t1_pend", bus.o_rdata, 32'h01);
        step(1'b0, 2'd2, 32'h0, 1'b1, 8'h00);
        chk("t1_status", bus.o_rdata, 32'h8000_0000);
        step(1'b1, 2'd3, 32'h0, 1'b0, 8'h00);

        // 2: simultaneous lines 5 and 2
        step(1'b1, 2'd1, 32'hFF, 1'b0, 8'h00);
        idle(2'd2, 8'h24);
        for (int i = 0; i < 3; i++) idle(2'd2, 8'h00);
        chk("t2_ext", {31'b0, bus.o_external_interrupt}, 32'h1);
        chk("t2_id", {29'b0, bus.o_irq_id}, 32'h2);
        step(1'b0, 2'd0, 32'h0, 1'b1, 8'h00);
        chk("t2_pend", bus.o_rdata, 32'h20);
        idle(2'd2, 8'h00);
        chk("t2_status", bus.o_rdata, 32'h8000_0002);
        step(1'b1, 2'd3, 32'h0, 1'b0, 8'h00);
        idle(2'd2, 8'h00);
        chk("t2_id5", {29'b0, bus.o_irq_id}, 32'h5);
        chk("t2_ext5", {31'b0, bus.o_external_interrupt}, 32'h1);
        step(1'b0, 2'd0, 32'h0, 1'b1, 8'h00);
        step(1'b1, 2'd3, 32'h0, 1'b0, 8'h00);

        // 3: masked event, then unmask
        step(1'b1, 2'd1, 32'h00, 1'b0, 8'h00);
        step(1'b1, 2'd0, 32'hFF, 1'b0, 8'h00);
        idle(2'd0, 8'h08);
        for (int i = 0; i < 3; i++) idle(2'd0, 8'h00);
        chk("t3_noext", {31'b0, bus.o_external_interrupt}, 32'h0);
        chk("t3_pend", bus.o_rdata, 32'h08);
        step(1'b1, 2'd1, 32'h08, 1'b0, 8'h00);
        idle(2'd2, 8'h00);
        chk("t3_ext", {31'b0, bus.o_external_interrupt}, 32'h1);
        chk("t3_id", {29'b0, bus.o_irq_id}, 32'h3);
        step(1'b0, 2'd0, 32'h0, 1'b1, 8'h00);
        step(1'b1, 2'd3, 32'h0, 1'b0, 8'h00);

        // 4: re-trigger of the line in service waits for EOI
        step(1'b1, 2'd1, 32'h02, 1'b0, 8'h00);
        idle(2'd0, 8'h02);
        for (int i = 0; i < 3; i++) idle(2'd0, 8'h00);
        step(1'b0, 2'd0, 32'h0, 1'b1, 8'h00);
        idle(2'd0, 8'h02);
        for (int i = 0; i < 4; i++) idle(2'd0, 8'h00);
        chk("t4_pend", bus.o_rdata, 32'h02);
        chk("t4_noext", {31'b0, bus.o_external_interrupt}, 32'h0);
        step(1'b1, 2'd3, 32'h0, 1'b0, 8'h00);
        idle(2'd2, 8'h00);
        chk("t4_ext", {31'b0, bus.o_external_interrupt}, 32'h1);
        chk("t4_id", {29'b0, bus.o_irq_id}, 32'h1);
        step(1'b0, 2'd0, 32'h0, 1'b1, 8'h00);
        step(1'b1, 2'd3, 32'h0, 1'b0, 8'h00);

        // 5: W1C colliding with an edge on the same bit
        step(1'b1, 2'd1, 32'h00, 1'b0, 8'h00);
        step(1'b1, 2'd0, 32'hFF, 1'b0, 8'h00);
        idle(2'd0, 8'h04);
        idle(2'd0, 8'h00);
        step(1'b1, 2'd0, 32'h04, 1'b0, 8'h00);
        chk("t5_setwins", bus.o_rdata, 32'h04);
        step(1'b1, 2'd0, 32'h04, 1'b0, 8'h00);
        chk("t5_clear", bus.o_rdata, 32'h00);

        // 6: reset while presenting, line 4 held high across release
        step(1'b1, 2'd1, 32'h01, 1'b0, 8'h00);
        idle(2'd0, 8'h01);
        for (int i = 0; i < 3; i++) idle(2'd0, 8'h00);
        chk("t6_req", {31'b0, bus.o_external_interrupt}, 32'h1);
        apply_reset(8'h10);
        step(1'b1, 2'd1, 32'h10, 1'b0, 8'h10);
        for (int i = 0; i < 3; i++) idle(2'd2, 8'h10);
        chk("t6_ext", {31'b0, bus.o_external_interrupt}, 32'h1);
        chk("t6_id", {29'b0, bus.o_irq_id}, 32'h4);
        step(1'b0, 2'd0, 32'h0, 1'b1, 8'h10);
        step(1'b1, 2'd3, 32'h0, 1'b0, 8'h10);
        for (int i = 0; i < 6; i++) idle(2'd0, 8'h10);
        chk("t6_once", {31'b0, bus.o_external_interrupt}, 32'h0);

        // Randomised traffic
        r_irq = 8'h10;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) apply_reset(r_irq);
            r_irq = r_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            we    = ($urandom_range(0, 9) == 0);
            addr  = 2'($urandom);
            wd    = $urandom;
            if (m_mode == 2 && $urandom_range(0, 7) == 0) begin
                we = 1'b1; addr = 2'd3;
            end
            ack = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            step(we, addr, wd, ack, r_irq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
